vx_ahb_burst_adapter: RTL and testbench

Parametrised bridge from the Vortex memory request/response interface to an AHB-Lite (AHB5 write-strobe) master port. Each Vortex request moves one line as a single pipelined incrementing AHB burst with overlapped address/data phases, forwards byte enables as HWSTRB, returns the tag with read data, and terminates early on HRESP errors. Sits between the Vortex memory port and the SoC AHB fabric, one instance per memory channel.

---
 rtl/vx_ahb_burst_adapter.sv | 227 ++++++++++++++++++++++
 tb/tb_vx_ahb_burst_adapter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ahb_burst_adapter.sv
// Vortex memory port to AHB-Lite (AHB5 HWSTRB) bridge: each request moves one line as a
// single pipelined incrementing burst; read data returns with the request tag.
module vx_ahb_burst_adapter #(
    parameter int unsigned VX_DATA_WIDTH  = 512,
    parameter int unsigned VX_ADDR_WIDTH  = 32 - $clog2(VX_DATA_WIDTH / 8),
    parameter int unsigned VX_TAG_WIDTH   = 8,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned AHB_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_req_valid,
    output logic                        mem_req_ready,
    input  logic                        mem_req_rw,
    input  logic [VX_DATA_WIDTH/8-1:0]  mem_req_byteen,
    input  logic [VX_ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic [VX_DATA_WIDTH-1:0]    mem_req_data,
    input  logic [VX_TAG_WIDTH-1:0]     mem_req_tag,
    output logic                        mem_rsp_valid,
    input  logic                        mem_rsp_ready,
    output logic [VX_DATA_WIDTH-1:0]    mem_rsp_data,
    output logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag,
    output logic                        mem_rsp_error,
    output logic                        bus_error,
    output logic                        HSEL,
    output logic                        HWRITE,
    output logic [AHB_ADDR_WIDTH-1:0]   HADDR,
    output logic [1:0]                  HTRANS,
    output logic [2:0]                  HSIZE,
    output logic [2:0]                  HBURST,
    output logic [AHB_DATA_WIDTH-1:0]   HWDATA,
    output logic [AHB_DATA_WIDTH/8-1:0] HWSTRB,
    input  logic [AHB_DATA_WIDTH-1:0]   HRDATA,
    input  logic                        HREADY,
    input  logic                        HRESP
);
    localparam int unsigned BEATS    = VX_DATA_WIDTH / AHB_DATA_WIDTH;
    localparam int unsigned BYTE_OFF = $clog2(VX_DATA_WIDTH / 8);
    localparam int unsigned STRB_W   = AHB_DATA_WIDTH / 8;
    localparam int unsigned ASIZE    = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(BEATS);
    localparam int unsigned CNT_W    = IDX_W + 1;
    localparam int unsigned LINE_W   = VX_ADDR_WIDTH + BYTE_OFF;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_CODE = (BEATS == 16) ? 3'b111 :
                                        (BEATS == 8)  ? 3'b101 :
                                        (BEATS == 4)  ? 3'b011 : 3'b001;

    typedef enum logic [2:0] {
        StIdle,
        StBurst,
        StDrain,
        StResp,
        StErr
    } state_e;

    state_e                      state_q, state_d;
    logic                        rw_q, rw_d;
    logic [VX_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [VX_DATA_WIDTH/8-1:0]  byteen_q, byteen_d;
    logic [VX_TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [AHB_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]            addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0]            data_cnt_q, data_cnt_d;
    logic [VX_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        bus_err_q, bus_err_d;

    logic [LINE_W-1:0]           line_byte_addr;
    logic [IDX_W-1:0]            data_idx;
    logic                        data_pending;
    logic                        data_phase;
    logic                        err_first;

    assign line_byte_addr = {mem_req_addr, {BYTE_OFF{1'b0}}};
    assign data_idx       = data_cnt_q[IDX_W-1:0];

    // A data phase is outstanding once an address phase has been accepted ahead of it.
    assign data_pending = ((state_q == StBurst) && (addr_cnt_q != data_cnt_q)) ||
                          (state_q == StDrain);
    assign data_phase   = data_pending || (state_q == StErr);
    assign err_first    = data_pending && HRESP && !HREADY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            byteen_q   <= '0;
            tag_q      <= '0;
            base_q     <= '0;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            byteen_q   <= byteen_d;
            tag_q      <= tag_d;
            base_q     <= base_d;
            addr_cnt_q <= addr_cnt_d;
            data_cnt_q <= data_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        byteen_d   = byteen_q;
        tag_d      = tag_q;
        base_d     = base_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        bus_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_req_valid) begin
                    rw_d       = mem_req_rw;
                    wdata_d    = mem_req_data;
                    byteen_d   = mem_req_byteen;
                    tag_d      = mem_req_tag;
                    base_d     = AHB_ADDR_WIDTH'(line_byte_addr);
                    addr_cnt_d = '0;
                    data_cnt_d = '0;
                    // Beats never filled (error cut-off) must read back as zero.
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (err_first) begin
                    state_d = StErr;
                end else if (HREADY) begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    if (data_pending) begin
                        if (!rw_q) begin
                            rdata_d[AHB_DATA_WIDTH*data_idx +: AHB_DATA_WIDTH] = HRDATA;
                        end
                        data_cnt_d = data_cnt_q + 1'b1;
                    end
                    if (addr_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (err_first) begin
                    state_d = StErr;
                end else if (HREADY) begin
                    if (!rw_q) begin
                        rdata_d[AHB_DATA_WIDTH*data_idx +: AHB_DATA_WIDTH] = HRDATA;
                    end
                    data_cnt_d = data_cnt_q + 1'b1;
                    state_d    = rw_q ? StIdle : StResp;
                end
            end
            StResp: begin
                if (mem_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                // Second cycle of the two-cycle error response.
                if (HREADY) begin
                    bus_err_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = rw_q ? StIdle : StResp;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_req_ready = (state_q == StIdle);
        mem_rsp_valid = (state_q == StResp);
        mem_rsp_data  = rdata_q;
        mem_rsp_tag   = tag_q;
        mem_rsp_error = (state_q == StResp) && err_q;
        bus_error     = bus_err_q;

        HSIZE  = 3'(ASIZE);
        HBURST = BURST_CODE;
        HSEL   = (state_q == StBurst);
        HWRITE = (state_q == StBurst) && rw_q;
        HADDR  = '0;
        HTRANS = TR_IDLE;
        HWDATA = '0;
        HWSTRB = '0;

        if (state_q == StBurst) begin
            HADDR = base_q + (AHB_ADDR_WIDTH'(addr_cnt_q) << ASIZE);
            if (!err_first) begin
                HTRANS = (addr_cnt_q == '0) ? TR_NONSEQ : TR_SEQ;
            end
        end

        if (data_phase && rw_q) begin
            HWDATA = wdata_q[AHB_DATA_WIDTH*data_idx +: AHB_DATA_WIDTH];
            HWSTRB = byteen_q[STRB_W*data_idx +: STRB_W];
        end
    end

endmodule

// File: tb/tb_vx_ahb_burst_adapter.sv
// Self-checking bench for vx_ahb_burst_adapter: 512/32 instance against a pipelined AHB slave
// model with stalls and errors, plus a 256/64 instance for the 4-beat configuration.
module tb_vx_ahb_burst_adapter;
    localparam int VXW = 512, AW = 26, TW = 8, DW = 32, BEATS = 16, BW = VXW / 8;
    localparam int VXW2 = 256, AW2 = 27, DW2 = 64, BEATS2 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_rw = 1'b0, rsp_ready = 1'b0;
    logic            req_ready, rsp_valid, rsp_error, bus_err;
    logic [BW-1:0]   req_byteen = '0;
    logic [AW-1:0]   req_addr = '0;
    logic [VXW-1:0]  req_data = '0, rsp_data;
    logic [TW-1:0]   req_tag = '0, rsp_tag;
    logic            hsel, hwrite;
    logic [31:0]     haddr, hwdata;
    logic [1:0]      htrans;
    logic [2:0]      hsize, hburst;
    logic [3:0]      hwstrb;
    logic [31:0]     hrdata = '0;
    logic            hready = 1'b1, hresp = 1'b0;

    logic            req2_valid = 1'b0;
    logic            req2_ready, rsp2_valid, rsp2_error, bus_err2;
    logic [AW2-1:0]  req2_addr = '0;
    logic [VXW2-1:0] rsp2_data;
    logic [TW-1:0]   req2_tag = '0, rsp2_tag;
    logic            hsel2, hwrite2;
    logic [31:0]     haddr2;
    logic [1:0]      htrans2;
    logic [2:0]      hsize2, hburst2;
    logic [63:0]     hwdata2, hrdata2 = '0;
    logic [7:0]      hwstrb2;

    vx_ahb_burst_adapter #(
        .VX_DATA_WIDTH(VXW), .VX_ADDR_WIDTH(AW), .VX_TAG_WIDTH(TW),
        .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
        .mem_req_byteen(req_byteen), .mem_req_addr(req_addr), .mem_req_data(req_data),
        .mem_req_tag(req_tag), .mem_rsp_valid(rsp_valid), .mem_rsp_ready(rsp_ready),
        .mem_rsp_data(rsp_data), .mem_rsp_tag(rsp_tag), .mem_rsp_error(rsp_error),
        .bus_error(bus_err), .HSEL(hsel), .HWRITE(hwrite), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(hrdata),
        .HREADY(hready), .HRESP(hresp)
    );

    vx_ahb_burst_adapter #(
        .VX_DATA_WIDTH(VXW2), .VX_ADDR_WIDTH(AW2), .VX_TAG_WIDTH(TW),
        .AHB_DATA_WIDTH(DW2), .AHB_ADDR_WIDTH(32)
    ) dut2 (
        .clk(clk), .reset(reset),
        .mem_req_valid(req2_valid), .mem_req_ready(req2_ready), .mem_req_rw(1'b0),
        .mem_req_byteen('0), .mem_req_addr(req2_addr), .mem_req_data('0),
        .mem_req_tag(req2_tag), .mem_rsp_valid(rsp2_valid), .mem_rsp_ready(1'b1),
        .mem_rsp_data(rsp2_data), .mem_rsp_tag(rsp2_tag), .mem_rsp_error(rsp2_error),
        .bus_error(bus_err2), .HSEL(hsel2), .HWRITE(hwrite2), .HADDR(haddr2), .HTRANS(htrans2),
        .HSIZE(hsize2), .HBURST(hburst2), .HWDATA(hwdata2), .HWSTRB(hwstrb2), .HRDATA(hrdata2),
        .HREADY(1'b1), .HRESP(1'b0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pipelined AHB slave: decides HREADY/HRESP/HRDATA per cycle, logs accepted transfers.
    int          stall_beat = -1, stall_left = 0, err_beat = -1, err_phase = 0, dp_idx = 0;
    int          unstable = 0, err_idle_bad = 0;
    logic [31:0] rd_seed = '0;
    logic        dp_valid = 1'b0, dp_write = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_haddr = '0, prev_hwdata = '0;
    logic [1:0]  prev_htrans = '0;
    logic [31:0] addr_log[$], wdata_log[$];
    logic [1:0]  trans_log[$];
    logic        write_log[$];
    logic [3:0]  wstrb_log[$];

    always @(negedge clk) begin
        if (reset) begin
            dp_valid = 1'b0;
            hready = 1'b1;
            hresp = 1'b0;
            hrdata = '0;
            prev_stall = 1'b0;
        end else begin
            hready = 1'b1;
            hresp = 1'b0;
            if (dp_valid && dp_idx == err_beat) begin
                hresp = 1'b1;
                hready = (err_phase == 1);
            end else if (dp_valid && dp_idx == stall_beat && stall_left > 0) begin
                hready = 1'b0;
                stall_left--;
            end
            hrdata = (dp_valid && !dp_write) ? rd_seed + 32'(dp_idx) : '0;
            #1;
            if (hresp && !hready && htrans != 2'b00) err_idle_bad++;
            if (prev_stall && (haddr !== prev_haddr || htrans !== prev_htrans ||
                               hwdata !== prev_hwdata)) unstable++;
            if (hready) begin
                if (dp_valid) begin
                    if (dp_write && !hresp) begin
                        wdata_log.push_back(hwdata);
                        wstrb_log.push_back(hwstrb);
                    end
                    dp_idx++;
                end
                if (hresp) begin
                    err_beat = -1;
                    err_phase = 0;
                end
                dp_valid = htrans[1];
                if (htrans[1]) begin
                    dp_write = hwrite;
                    addr_log.push_back(haddr);
                    trans_log.push_back(htrans);
                    write_log.push_back(hwrite);
                end
            end else if (hresp) begin
                err_phase = 1;
            end
            prev_stall = !hready && !hresp;
            prev_haddr = haddr;
            prev_htrans = htrans;
            prev_hwdata = hwdata;
        end
    end

    // Always-ready slave for the 64-bit instance: read data encodes the beat address.
    logic        dp2_valid = 1'b0;
    logic [31:0] dp2_addr = '0;
    logic [31:0] addr2_log[$];

    always @(negedge clk) begin
        hrdata2 = dp2_valid ? {32'hC0DE_0000, dp2_addr} : '0;
        #1;
        dp2_valid = htrans2[1] && !reset;
        if (dp2_valid) begin
            dp2_addr = haddr2;
            addr2_log.push_back(haddr2);
        end
    end

    task automatic run_txn(input logic rw, input logic [AW-1:0] la, input logic [VXW-1:0] wd,
                           input logic [BW-1:0] be, input logic [TW-1:0] tg,
                           input int s_beat, input int s_len, input int e_beat, input int bp);
        int n, berr, rsp_seen, exp_lat, nb, bad;
        logic [31:0] base;
        logic [VXW-1:0] exp_data;
        @(negedge clk);
        #2;
        addr_log.delete(); trans_log.delete(); write_log.delete();
        wdata_log.delete(); wstrb_log.delete();
        dp_idx = 0; stall_beat = s_beat; stall_left = s_len; err_beat = e_beat; err_phase = 0;
        unstable = 0; err_idle_bad = 0;
        check("req_ready_idle", req_ready, 1'b1);
        req_rw = rw; req_addr = la; req_data = wd; req_byteen = be; req_tag = tg;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0; berr = 0; rsp_seen = 0;
        while (n < 200) begin
            @(negedge clk);
            #2;
            n++;
            if (bus_err) berr++;
            if (rsp_valid) rsp_seen++;
            if ((!rw && rsp_valid) || (rw && req_ready)) break;
        end
        nb = (e_beat >= 0) ? e_beat : BEATS;
        exp_lat = (e_beat >= 0) ? e_beat + 4 :
                  BEATS + 2 + ((s_beat >= 0 && s_beat < BEATS) ? s_len : 0);
        check(rw ? "wr_done_cycle" : "rd_rsp_cycle", n, exp_lat);
        base = 32'(la) << 6;
        check("addr_count", addr_log.size(), (e_beat >= 0) ? e_beat + 1 : BEATS);
        bad = 0;
        foreach (addr_log[k]) begin
            if (addr_log[k] !== base + 32'(4 * k) || write_log[k] !== rw ||
                trans_log[k] !== ((k == 0) ? 2'b10 : 2'b11)) bad++;
        end
        check("addr_phase_seq", bad, 0);
        check("stall_hold", unstable, 0);
        check("err_htrans_idle", err_idle_bad, 0);
        if (rw) begin
            check("wr_no_rsp", rsp_seen, 0);
            check("wr_beat_count", wdata_log.size(), nb);
            bad = 0;
            foreach (wdata_log[k]) begin
                if (wdata_log[k] !== wd[k*32 +: 32] || wstrb_log[k] !== be[k*4 +: 4]) bad++;
            end
            check("wr_beats", bad, 0);
        end else begin
            exp_data = '0;
            for (int k = 0; k < nb; k++) exp_data[k*32 +: 32] = rd_seed + 32'(k);
            check("rd_data", rsp_data, exp_data);
            check("rd_tag", rsp_tag, tg);
            check("rd_error", rsp_error, (e_beat >= 0));
            bad = 0;
            for (int c = 0; c < bp; c++) begin
                @(negedge clk);
                #2;
                if (bus_err) berr++;
                if (!rsp_valid || rsp_data !== exp_data || rsp_tag !== tg) bad++;
            end
            check("rsp_backpressure_hold", bad, 0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            #2;
            if (bus_err) berr++;
            check("rsp_retired", {rsp_valid, req_ready}, 2'b01);
        end
        check("bus_error_pulses", berr, (e_beat >= 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VXW-1:0] wd;
        logic [BW-1:0]  be;
        logic [AW-1:0]  la;
        logic [AW2-1:0] la2;
        logic [VXW2-1:0] exp2;
        logic [31:0]    base2;
        int n, bad;

        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_ahb", {hsel, hwrite, htrans, haddr, hwdata, hwstrb}, '0);
        check("rst_rsp", {rsp_valid, rsp_error, bus_err, rsp_tag}, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("hsize_hburst_32", {hsize, hburst}, {3'b010, 3'b111});
        reset = 1'b0;

        rd_seed = 32'hA000_0000;
        run_txn(1'b0, 26'h40, '0, '0, 8'h5A, -1, 0, -1, 0);

        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = $urandom();
        run_txn(1'b1, 26'h123, wd, 64'hFFFF_0000_0000_000F, 8'h11, -1, 0, -1, 0);

        rd_seed = 32'h5500_0000;
        run_txn(1'b0, 26'h2_0000, '0, '0, 8'h22, 5, 3, -1, 0);

        rd_seed = 32'h7700_0010;
        run_txn(1'b0, 26'h3F_FFFF, '0, '0, 8'h33, -1, 0, 3, 5);

        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = $urandom();
        run_txn(1'b1, 26'h77, wd, {$urandom(), $urandom()}, 8'h44, -1, 0, 2, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) wd[i*32 +: 32] = $urandom();
            be = {$urandom(), $urandom()};
            la = AW'($urandom());
            rd_seed = $urandom();
            run_txn(1'($urandom_range(0, 1)), la, wd, be, 8'($urandom()),
                    $urandom_range(0, 15), $urandom_range(0, 3), -1, $urandom_range(0, 3));
        end

        // 256/64 instance: 4-beat INCR4 with 8-byte address step.
        check("hsize_hburst_64", {hsize2, hburst2}, {3'b011, 3'b011});
        la2 = AW2'($urandom());
        @(negedge clk);
        #2;
        addr2_log.delete();
        req2_addr = la2; req2_tag = 8'h9C; req2_valid = 1'b1;
        @(posedge clk);
        #1;
        req2_valid = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            #2;
            n++;
            if (rsp2_valid) break;
        end
        check("w64_rsp_cycle", n, BEATS2 + 2);
        base2 = 32'(la2) << 5;
        check("w64_addr_count", addr2_log.size(), BEATS2);
        bad = 0;
        foreach (addr2_log[k]) if (addr2_log[k] !== base2 + 32'(8 * k)) bad++;
        check("w64_addr_step", bad, 0);
        exp2 = '0;
        for (int k = 0; k < BEATS2; k++) exp2[k*64 +: 64] = {32'hC0DE_0000, base2 + 32'(8 * k)};
        check("w64_rd_data", rsp2_data, exp2);
        check("w64_rd_tag", rsp2_tag, 8'h9C);

        // Reset asserted mid-burst, away from any clock edge.
        @(negedge clk);
        #2;
        dp_idx = 0; stall_beat = -1; err_beat = -1; rd_seed = 32'h1234_0000;
        req_rw = 1'b0; req_addr = 26'h0A_BCDE; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_ahb", {hsel, hwrite, htrans, haddr, hwdata, hwstrb}, '0);
        check("async_rst_ctrl", {req_ready, rsp_valid, rsp_error, bus_err}, 4'b1000);
        check("async_rst_data", rsp_data, '0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            #2;
            if (rsp_valid || !req_ready) n++;
        end
        check("no_rsp_after_reset", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
